// File: rtl/mem_rw_sched_pkg.sv
// Shared constants for mem_rw_sched: AXI size codes, requester ids, request bit positions
// and scheduler FSM states.
package mem_rw_sched_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  localparam logic [3:0] ID_ICACHE  = 4'd0;
  localparam logic [3:0] ID_DCACHE  = 4'd1;
  localparam logic [3:0] ID_UNCACHE = 4'd2;

  // Bit positions of each requester in the request / grant vectors
  localparam int unsigned REQ_I = 0;
  localparam int unsigned REQ_D = 1;
  localparam int unsigned REQ_U = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/mem_rw_sched_pick.sv
// rw_grant_pick: combinational one-hot winner selector for mem_rw_sched.
// ARB_RR_EN selects round-robin on last winner; otherwise fixed priority with starve override.
module rw_grant_pick
  import mem_rw_sched_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [2:0] last_i,
  input  logic       starve_i,
  output logic [2:0] gnt_o
);

`ifdef ARB_RR_EN
  logic unused_starve;
  assign unused_starve = starve_i;

  // The requester after the most recent winner gets first pick
  always_comb begin
    gnt_o = '0;
    unique case (last_i)
      3'b001: begin
        if (req_i[REQ_D])      gnt_o[REQ_D] = 1'b1;
        else if (req_i[REQ_U]) gnt_o[REQ_U] = 1'b1;
        else if (req_i[REQ_I]) gnt_o[REQ_I] = 1'b1;
      end
      3'b010: begin
        if (req_i[REQ_U])      gnt_o[REQ_U] = 1'b1;
        else if (req_i[REQ_I]) gnt_o[REQ_I] = 1'b1;
        else if (req_i[REQ_D]) gnt_o[REQ_D] = 1'b1;
      end
      default: begin
        if (req_i[REQ_I])      gnt_o[REQ_I] = 1'b1;
        else if (req_i[REQ_D]) gnt_o[REQ_D] = 1'b1;
        else if (req_i[REQ_U]) gnt_o[REQ_U] = 1'b1;
      end
    endcase
  end
`else
  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    gnt_o = '0;
    if (starve_i && req_i[REQ_I]) gnt_o[REQ_I] = 1'b1;
    else if (req_i[REQ_U])        gnt_o[REQ_U] = 1'b1;
    else if (req_i[REQ_D])        gnt_o[REQ_D] = 1'b1;
    else if (req_i[REQ_I])        gnt_o[REQ_I] = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_rw_sched.sv
// Scheduler sharing one AXI rw channel between icache refill, dcache and uncached access.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority with starve counter.
module mem_rw_sched
  import mem_rw_sched_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [1:0]  SZ_D       = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_re_i,
  input  logic [63:0] icache_addr_i,
  output logic [63:0] icache_data_o,
  output logic        icache_done_o,
  input  logic        dcache_re_i,
  input  logic        dcache_we_i,
  input  logic [31:0] dcache_addr_i,
  input  logic [63:0] dcache_wdata_i,
  input  logic [7:0]  dcache_mask_i,
  input  logic [1:0]  dcache_size_i,
  output logic [63:0] dcache_rdata_o,
  output logic        dcache_done_o,
  input  logic        uncache_re_i,
  input  logic        uncache_we_i,
  input  logic [31:0] uncache_addr_i,
  input  logic [63:0] uncache_wdata_i,
  input  logic [7:0]  uncache_mask_i,
  input  logic [1:0]  uncache_size_i,
  output logic [63:0] uncache_rdata_o,
  output logic        uncache_done_o,
  output logic        rw_valid_o,
  input  logic        rw_ready_i,
  output logic        rw_req_o,
  output logic [63:0] rw_addr_o,
  output logic [1:0]  rw_size_o,
  output logic [63:0] data_write_o,
  output logic [7:0]  w_mask_o,
  output logic [3:0]  rw_id_o,
  input  logic [3:0]  rw_id_i,
  input  logic [63:0] data_read_i
);

  state_e      state_q;
  logic        valid_q, we_q;
  logic [63:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [7:0]  mask_q;
  logic [3:0]  id_q;
  logic [2:0]  done_q;
  logic [63:0] ic_rdata_q, dc_rdata_q, uc_rdata_q;

  logic [2:0]  req;
  logic [2:0]  gnt;
  logic [2:0]  last;
  logic        starve;

  assign req[REQ_I] = icache_re_i;
  assign req[REQ_D] = dcache_re_i | dcache_we_i;
  assign req[REQ_U] = uncache_re_i | uncache_we_i;

`ifdef ARB_RR_EN
  logic [2:0] last_q;

  assign last   = last_q;
  assign starve = 1'b0;

  // Reset as if uncache won last, giving icache > dcache > uncache
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 3'b100;
    end else if (state_q == StIdle && |req) begin
      last_q <= gnt;
    end
  end
`else
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  logic [StarveW-1:0] starve_q;

  assign last   = 3'b100;
  assign starve = (starve_q == StarveW'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (state_q == StIdle) begin
      if (!icache_re_i || gnt[REQ_I]) begin
        starve_q <= '0;
      end else if (|req && !starve) begin
        starve_q <= starve_q + StarveW'(1);
      end
    end
  end
`endif

  rw_grant_pick u_pick (
    .req_i    (req),
    .last_i   (last),
    .starve_i (starve),
    .gnt_o    (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      mask_q     <= '0;
      id_q       <= '0;
      done_q     <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
      uc_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= '0;
          if (|req) begin
            state_q <= StBusy;
            valid_q <= 1'b1;
            unique case (1'b1)
              gnt[REQ_U]: begin
                id_q    <= ID_UNCACHE;
                we_q    <= uncache_we_i;
                addr_q  <= {32'h0, uncache_addr_i};
                wdata_q <= uncache_wdata_i;
                mask_q  <= uncache_we_i ? uncache_mask_i : 8'h00;
                size_q  <= uncache_size_i;
              end
              gnt[REQ_D]: begin
                id_q    <= ID_DCACHE;
                we_q    <= dcache_we_i;
                addr_q  <= {32'h0, dcache_addr_i};
                wdata_q <= dcache_wdata_i;
                mask_q  <= dcache_we_i ? dcache_mask_i : 8'h00;
                size_q  <= dcache_size_i;
              end
              default: begin
                id_q    <= ID_ICACHE;
                we_q    <= 1'b0;
                addr_q  <= icache_addr_i;
                wdata_q <= '0;
                mask_q  <= 8'h00;
                size_q  <= SZ_D;
              end
            endcase
          end
        end
        StBusy: begin
          // Responses tagged for another owner are ignored
          if (rw_ready_i && rw_id_i == id_q) begin
            state_q <= StDone;
            valid_q <= 1'b0;
            unique case (id_q)
              ID_ICACHE: begin
                done_q <= 3'b001;
                if (!we_q) ic_rdata_q <= data_read_i;
              end
              ID_DCACHE: begin
                done_q <= 3'b010;
                if (!we_q) dc_rdata_q <= data_read_i;
              end
              default: begin
                done_q <= 3'b100;
                if (!we_q) uc_rdata_q <= data_read_i;
              end
            endcase
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rw_valid_o      = valid_q;
  assign rw_req_o        = we_q;
  assign rw_addr_o       = addr_q;
  assign rw_size_o       = size_q;
  assign data_write_o    = wdata_q;
  assign w_mask_o        = mask_q;
  assign rw_id_o         = id_q;
  assign icache_done_o   = done_q[REQ_I];
  assign dcache_done_o   = done_q[REQ_D];
  assign uncache_done_o  = done_q[REQ_U];
  assign icache_data_o   = ic_rdata_q;
  assign dcache_rdata_o  = dc_rdata_q;
  assign uncache_rdata_o = uc_rdata_q;

endmodule

// File: doc/mem_rw_sched.md
Name: mem_rw_sched

Overview:
- Registered scheduler sharing the single AXI read/write channel between icache miss refill, dcache miss/writeback and uncached device access.
- Accepts level requests from the three requesters and grants exactly one at a time.
- Latches the granted request's address, data, mask and size, then holds rw_valid_o until the matching response arrives.
- Returns the read data and a one-cycle done pulse to the owner.
- Sits between the cache/uncache units and the AXI rw bridge.

Parameters:
- STARVE_MAX, 4: consecutive lost arbitrations after which a waiting icache request is forced to win (fixed-priority mode only).
- SZ_D, 2'b11: size code driven for icache refills.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- icache_re_i  in  1  icache refill request (level)
- icache_addr_i  in  64  refill address
- icache_data_o  out  64  refill data
- icache_done_o  out  1  completion pulse
- dcache_re_i / dcache_we_i  in  1 each  dcache read / write request
- dcache_addr_i  in  32  address
- dcache_wdata_i  in  64  writeback data
- dcache_mask_i  in  8  byte mask
- dcache_size_i  in  2  size code
- dcache_rdata_o  out  64  read data
- dcache_done_o  out  1  completion pulse
- uncache_re_i / uncache_we_i  in  1 each  device read / write
- uncache_addr_i  in  32  address
- uncache_wdata_i  in  64  write data
- uncache_mask_i  in  8  byte mask
- uncache_size_i  in  2  size code
- uncache_rdata_o  out  64  read data
- uncache_done_o  out  1  completion pulse
- rw_valid_o  out  1  transaction valid
- rw_ready_i  in  1  transaction complete
- rw_req_o  out  1  0 = read, 1 = write
- rw_addr_o  out  64  address
- rw_size_o  out  2  size
- data_write_o  out  64  write data
- w_mask_o  out  8  byte mask
- rw_id_o  out  4  owner id
- rw_id_i  in  4  response id
- data_read_i  in  64  read data

Behaviour:
- Reset:
  - All outputs 0; FSM = IDLE; starve counter = 0; rdata registers = 0.
  - Reset asserted mid-transaction aborts silently: no done pulse, rw_valid_o low next cycle.
- IDs: icache 4'd0, dcache 4'd1, uncache 4'd2.
- FSM IDLE:
  - If any request is asserted, pick a winner.
  - Latch id, we, address (32-bit inputs zero-extended to 64), wdata, mask (forced 0 for reads), size (SZ_D for icache).
  - Go to BUSY.
- FSM BUSY:
  - rw_valid_o = 1; all rw_* outputs driven from the latched registers and stable throughout.
  - On rw_ready_i && rw_id_i == latched id:
    - reads: capture data_read_i into the owner's rdata register;
    - pulse the owner's done output for exactly one cycle;
    - go to DONE.
  - rw_ready_i with a non-matching id is ignored.
- FSM DONE: one bubble cycle, rw_valid_o = 0, no grant issued; requester drops its request here. Then go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle N → rw_valid_o high at N+1.
  - Ready at cycle M → done and rdata at M+1.
  - Earliest next grant evaluated at M+2; back-to-back throughput is one transaction per 3 cycles minimum.
- rdata registers hold their value until the same requester's next read completes.
- A request dropped during BUSY does not cancel the transaction; done still pulses.
- Simultaneous re and we from the same requester: we wins (rw_req_o = 1).
- Fixed priority: uncache > dcache > icache.
  - Starve counter increments whenever icache_re_i is high and icache loses a grant; it saturates at STARVE_MAX.
  - When the counter equals STARVE_MAX, icache wins the next grant.
  - Counter clears on an icache grant, or when icache_re_i is low in IDLE.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration; the most recent winner becomes lowest priority; reset order is icache > dcache > uncache; the starve counter is not instantiated.
- Undefined: fixed priority with the starvation counter as above.

Decomposition:
- Shared defines package: SIZE_B/H/W/D codes, requester ID constants (ID_ICACHE/ID_DCACHE/ID_UNCACHE), FSM state encodings.
- One natural sub-module: rw_grant_pick, a combinational winner selector that takes the request vector, priority state and starve flag and outputs a one-hot grant. The FSM, latches and counters stay in the top module.

Test Plan:
- Single icache read to 0x8000_0000 → rw_valid_o next cycle, rw_id_o=0, rw_size_o=2'b11, rw_req_o=0. Ready at cycle 5 with data 0xDEADBEEF_CAFEF00D and id 0 → icache_done_o pulses once at cycle 6 with matching icache_data_o.
- dcache write to 0x8000_1000, mask 0x0F, data 0x1122334455667788 → rw_req_o=1, w_mask_o=0x0F, data_write_o matches; dcache_done_o pulses once; dcache_rdata_o unchanged.
- icache, dcache and uncache requesting in the same cycle (fixed priority) → grant order uncache, dcache, icache; each done separated by at least 3 cycles.
- uncache and dcache requesting continuously while icache waits → icache granted after exactly 4 losses.
- Ready with rw_id_i=2 while dcache (id 1) is owner → ignored, rw_valid_o stays 1. Later ready with id 1 → completes normally.
- rst asserted in BUSY → all outputs 0 the next cycle, no done pulse, FSM in IDLE. With ARB_RR_EN, three simultaneous continuous requests → grants rotate icache, dcache, uncache, icache.
